// File: rtl/clock_step_pkg.sv
// Shared types and constants for the CPU clock-enable generator.
package clock_step_pkg;

    // Top-level operating state of the tick generator.
    typedef enum logic [1:0] {
        S_STEP = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } step_state_t;

    // Flop count of every asynchronous-input synchroniser.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/debouncer.sv
// Push-button conditioner: synchronises the raw button, accepts a new level
// only after it has been stable for CYCLES clocks, and emits a one-cycle
// pulse when the accepted level rises.
module debouncer
    import clock_step_pkg::*;
#(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    // The counter only has to reach CYCLES-1 before the level flips.
    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   level_reg;
    logic                   level_next;
    logic                   rise_reg;
    logic                   rise_next;
    logic                   synced;

    assign synced = sync_reg[SYNC_STAGES-1];
    assign rise   = rise_reg;

    // Shift the raw button through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
        end
    end

    // Count consecutive cycles of disagreement; flip the level on the last one.
    always_comb begin
        cnt_next   = '0;
        level_next = level_reg;
        rise_next  = 1'b0;
        if (synced != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next = synced;
                rise_next  = synced;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    // Register the stable counter, accepted level and rising-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
        end
    end

endmodule

// File: rtl/clock_step_unit.sv
// CPU clock-enable generator: free-running at one of two rates, debounced
// single-step, and CPU halt. Produces a registered one-cycle tick, a wrapping
// tick counter and a running status bit.
module clock_step_unit
    import clock_step_pkg::*;
#(
    parameter int RATIO_SLOW      = 100_000_000,
    parameter int RATIO_FAST      = 1_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_W          = 16
) (
    input  logic              pin_clock,
    input  logic              pin_n_reset,
    input  logic              mode_run,
    input  logic              speed_sel,
    input  logic              step_btn,
    input  logic              halt,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              running
);

    localparam int RATIO_MAX = (RATIO_SLOW > RATIO_FAST) ? RATIO_SLOW : RATIO_FAST;
    localparam int PRE_W     = $clog2(RATIO_MAX);
    localparam logic [PRE_W-1:0] LAST_SLOW = PRE_W'(RATIO_SLOW - 1);
    localparam logic [PRE_W-1:0] LAST_FAST = PRE_W'(RATIO_FAST - 1);

    // Bit 0 = mode_run, bit 1 = speed_sel.
    logic [1:0] sw_raw;
    logic [1:0] sw_sync;
    logic       mode_sync;
    logic       speed_sync;
    logic       step_req;

    step_state_t       state_reg;
    step_state_t       state_next;
    logic [PRE_W-1:0]  prescale_reg;
    logic [PRE_W-1:0]  prescale_next;
    logic [PRE_W-1:0]  prescale_last;
    logic              speed_applied_reg;
    logic              speed_changed;
    logic              tick_reg;
    logic              tick_next;
    logic [TICK_W-1:0] tick_count_reg;
    logic              running_reg;

    assign sw_raw     = {speed_sel, mode_run};
    assign mode_sync  = sw_sync[0];
    assign speed_sync = sw_sync[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sw_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            // Two-flop synchroniser for one asynchronous switch.
            always_ff @(posedge pin_clock or negedge pin_n_reset) begin
                if (!pin_n_reset) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], sw_raw[gi]};
                end
            end
            assign sw_sync[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    debouncer #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk   (pin_clock),
        .rst_n (pin_n_reset),
        .raw   (step_btn),
        .rise  (step_req)
    );

    assign speed_changed = (speed_sync != speed_applied_reg);
    assign prescale_last = speed_sync ? LAST_FAST : LAST_SLOW;

    // Next state: halt beats run, run beats step.
    always_comb begin
        state_next = S_STEP;
        if (halt) begin
            state_next = S_HALT;
        end else if (mode_sync) begin
            state_next = S_RUN;
        end
    end

    // Prescaler and tick decision. Halt suppresses any tick outright; leaving
    // run clears the count. A speed change restarts the period with the change
    // cycle itself counted as 0, so the next tick is exactly RATIO_new later.
    always_comb begin
        prescale_next = '0;
        tick_next     = 1'b0;
        if (!halt) begin
            case (state_reg)
                S_RUN: begin
                    if (state_next == S_RUN) begin
                        if (speed_changed) begin
                            prescale_next = PRE_W'(1);
                        end else if (prescale_reg == prescale_last) begin
                            tick_next = 1'b1;
                        end else begin
                            prescale_next = prescale_reg + 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    tick_next = step_req;
                end
                default: begin
                end
            endcase
        end
    end

    // State, prescaler, tick and status registers.
    always_ff @(posedge pin_clock or negedge pin_n_reset) begin
        if (!pin_n_reset) begin
            state_reg         <= S_STEP;
            prescale_reg      <= '0;
            speed_applied_reg <= 1'b0;
            tick_reg          <= 1'b0;
            tick_count_reg    <= '0;
            running_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            prescale_reg      <= prescale_next;
            speed_applied_reg <= speed_sync;
            tick_reg          <= tick_next;
            running_reg       <= (state_reg == S_RUN);
            if (tick_next) begin
                tick_count_reg <= tick_count_reg + 1'b1;
            end
        end
    end

    assign tick       = tick_reg;
    assign tick_count = tick_count_reg;
    assign running    = running_reg;

endmodule
